// File: rtl/dp_run_ctrl.sv
// dp_run_ctrl: host-facing run controller for the 4-thread barrel-pipelined
// RISC-V datapath. Takes host commands over a valid/ready handshake, loads
// the instruction and data memories, pulses the datapath reset, and runs the
// pipeline for a bounded or unbounded number of cycles. A run always stops on
// a thread-round boundary and then waits for the pipeline to drain before
// reporting done.
module dp_run_ctrl #(
  parameter int D_WIDTH      = 64,
  parameter int ISTR_WIDTH   = 32,
  parameter int RST_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [9:0]            cmd_addr,
  input  logic [D_WIDTH-1:0]    cmd_data,
  input  logic [31:0]           cmd_count,
  input  logic                  halt_req,
  output logic                  dp_reset_n,
  output logic                  pc_en,
  output logic                  i_mem_we,
  output logic [31:0]           i_mem_addra,
  output logic [ISTR_WIDTH-1:0] i_mem_din,
  output logic                  d_mem_we,
  output logic [7:0]            d_mem_addra,
  output logic [D_WIDTH-1:0]    d_mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycles_run
);

  localparam logic [1:0] OP_LOAD_I = 2'd0;
  localparam logic [1:0] OP_LOAD_D = 2'd1;
  localparam logic [1:0] OP_RESET  = 2'd2;
  localparam logic [1:0] OP_RUN    = 2'd3;

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RST,
    S_RUN,
    S_ROUND,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [9:0]          addr_q;
  logic [D_WIDTH-1:0]  data_q;
  logic [31:0]         count_q;
  logic [31:0]         cycles_q;
  logic [15:0]         tmr_q;

  logic        accept;
  logic        cycles_sat;
  logic [31:0] cycles_inc;
  logic        count_hit;
  logic        on_round;

  assign accept     = cmd_valid && (state == S_IDLE);
  assign cycles_sat = (cycles_q == 32'hFFFF_FFFF);
  assign cycles_inc = cycles_sat ? cycles_q : cycles_q + 32'd1;
  assign count_hit  = (count_q != 32'd0) && (cycles_inc == count_q);
  // A saturated counter can never reach a multiple of 4 again, so treat
  // saturation as a round boundary to guarantee the run still terminates.
  assign on_round   = (cycles_inc[1:0] == 2'b00) || cycles_sat;

  // Next-state logic for the run/command sequencer.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_LOAD_I, OP_LOAD_D: state_nxt = S_WRITE;
            OP_RESET:             state_nxt = S_RST;
            OP_RUN:               state_nxt = S_RUN;
            default:              state_nxt = S_IDLE;
          endcase
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_RST:   if (tmr_q == RST_LAST) state_nxt = S_IDLE;
      S_RUN: begin
        if (count_hit || halt_req) state_nxt = on_round ? S_DRAIN : S_ROUND;
      end
      S_ROUND: if (on_round) state_nxt = S_DRAIN;
      S_DRAIN: if (tmr_q == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, captured command fields, run counter and phase timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      tmr_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state <= state_nxt;
      if (accept) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        data_q  <= cmd_data;
        count_q <= cmd_count;
        if (cmd_op == OP_RUN) cycles_q <= '0;
      end
      if (state == S_RUN || state == S_ROUND) cycles_q <= cycles_inc;
      // Timer restarts on every state change; only RST and DRAIN read it.
      if (state_nxt != state)                       tmr_q <= '0;
      else if (state == S_RST || state == S_DRAIN)  tmr_q <= tmr_q + 16'd1;
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign pc_en       = (state == S_RUN) || (state == S_ROUND);
  assign done        = (state == S_DONE);
  assign dp_reset_n  = !reset && (state != S_RST);
  assign i_mem_we    = (state == S_WRITE) && (op_q == OP_LOAD_I);
  assign d_mem_we    = (state == S_WRITE) && (op_q == OP_LOAD_D);
  assign i_mem_addra = {22'b0, addr_q};
  assign i_mem_din   = data_q[ISTR_WIDTH-1:0];
  assign d_mem_addra = addr_q[7:0];
  assign d_mem_din   = data_q;
  assign cycles_run  = cycles_q;

endmodule
